// File: rtl/cdpwm_pkg.sv
// cdpwm_pkg: shared helpers for the multi-channel countdown PWM
package cdpwm_pkg;
   function automatic int idx_w(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction
   function automatic int duty_lsb(input int i, input int w);
      return i * w;
   endfunction
endpackage

// File: rtl/cdpwm_channel.sv
// cdpwm_channel: double-buffered duty register, comparator and registered PWM output
module cdpwm_channel
   import cdpwm_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             sysclk,
   input  logic             sysreset,
   input  logic [WIDTH-1:0] cnt,
   input  logic             transfer,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] duty,
   output logic             pwm
);
   logic [WIDTH-1:0] shadow_q, shadow_d, active_q, active_d;
   logic pwm_q, pwm_d;
   // transfer takes shadow_d so a write on the rollover edge goes straight through
   always_comb begin
      shadow_d = load ? data_in : shadow_q;
      active_d = transfer ? shadow_d : active_q;
      pwm_d = cnt < active_q;
   end
   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         shadow_q <= '0;
         active_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pwm_q <= pwm_d;
      end
   end
   assign duty = active_q;
   assign pwm = pwm_q;
endmodule

// File: rtl/cdpwm_multi.sv
// cdpwm_multi: shared countdown counter with double-buffered period driving CHANNELS PWM outputs
module cdpwm_multi
   import cdpwm_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHANNELS = 4,
   parameter int START = 65535
) (
   input  logic                      sysclk,
   input  logic                      sysreset,
   input  logic                      counter_event,
   input  logic [WIDTH-1:0]          data_in,
   input  logic                      period_load,
   input  logic [CHANNELS-1:0]       duty_load,
   output logic [WIDTH-1:0]          counter_value,
   output logic [WIDTH-1:0]          period,
   output logic [CHANNELS*WIDTH-1:0] duty,
   output logic                      rollover,
   output logic [CHANNELS-1:0]       pwm_signal
);
   localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
   logic [WIDTH-1:0] cnt_q, cnt_d, period_q, period_d, act_period_q, act_period_d;
   logic event_last_q, event_last_d, rollover_q, rollover_d;
   logic event_edge, transfer;
   always_comb begin
      event_edge = counter_event & ~event_last_q;
      transfer = event_edge & (cnt_q == '0);
      event_last_d = counter_event;
      period_d = period_load ? data_in : period_q;
      act_period_d = transfer ? period_d : act_period_q;
      cnt_d = transfer ? act_period_d : event_edge ? cnt_q - 1'b1 : cnt_q;
      rollover_d = transfer;
   end
   always_ff @(posedge sysclk) begin
      if (sysreset) begin
         cnt_q <= START_V;
         period_q <= START_V;
         act_period_q <= START_V;
         event_last_q <= 1'b0;
         rollover_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         period_q <= period_d;
         act_period_q <= act_period_d;
         event_last_q <= event_last_d;
         rollover_q <= rollover_d;
      end
   end
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      localparam int LSB = duty_lsb(g, WIDTH);
      cdpwm_channel #(.WIDTH(WIDTH)) u_ch (
         .sysclk  (sysclk),
         .sysreset(sysreset),
         .cnt     (cnt_q),
         .transfer(transfer),
         .load    (duty_load[g]),
         .data_in (data_in),
         .duty    (duty[LSB +: WIDTH]),
         .pwm     (pwm_signal[g])
      );
   end
   assign counter_value = cnt_q;
   assign period = period_q;
   assign rollover = rollover_q;
endmodule

// File: tb/tb_cdpwm_multi.sv
// tb_cdpwm_multi: scoreboard bench comparing cdpwm_multi against a behavioural model
module tb_cdpwm_multi;
   localparam int W = 8;
   localparam int CH = 4;
   localparam int ST = 9;
   typedef struct {
      logic [W-1:0]    cnt;
      logic [W-1:0]    per;
      logic [CH*W-1:0] duty;
      logic            roll;
      logic [CH-1:0]   pwm;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ev = 1'b0;
   logic [W-1:0] din = '0;
   logic pl = 1'b0;
   logic [CH-1:0] dl = '0;
   logic [W-1:0] counter_value, period;
   logic [CH*W-1:0] duty;
   logic rollover;
   logic [CH-1:0] pwm_signal;
   int tests = 0;
   int fails = 0;
   exp_t q[$];
   int m_cnt, m_psh, m_pact;
   int m_dsh[CH], m_dact[CH];
   logic m_last, m_roll;
   logic [CH-1:0] m_pwm;
   always #5 clk = ~clk;
   cdpwm_multi #(.WIDTH(W), .CHANNELS(CH), .START(ST)) dut (
      .sysclk       (clk),
      .sysreset     (rst),
      .counter_event(ev),
      .data_in      (din),
      .period_load  (pl),
      .duty_load    (dl),
      .counter_value(counter_value),
      .period       (period),
      .duty         (duty),
      .rollover     (rollover),
      .pwm_signal   (pwm_signal)
   );
   task automatic chk(input string name, input logic [CH*W-1:0] act, input logic [CH*W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // monitor: one expected snapshot per clock edge, sampled well after the edge
   always begin
      @(posedge clk);
      #3;
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("counter_value", CH*W'(counter_value), CH*W'(e.cnt));
         chk("period", CH*W'(period), CH*W'(e.per));
         chk("duty", duty, e.duty);
         chk("rollover", CH*W'(rollover), CH*W'(e.roll));
         chk("pwm_signal", CH*W'(pwm_signal), CH*W'(e.pwm));
      end
   end
   task automatic step(input logic r, input logic e, input logic p, input logic [CH-1:0] d, input int v);
      exp_t x;
      logic edge_seen;
      @(negedge clk);
      rst = r; ev = e; pl = p; dl = d; din = W'(v);
      if (r) begin
         m_cnt = ST; m_psh = ST; m_pact = ST; m_last = 0; m_roll = 0; m_pwm = '0;
         for (int i = 0; i < CH; i++) begin m_dsh[i] = 0; m_dact[i] = 0; end
      end else begin
         for (int i = 0; i < CH; i++) m_pwm[i] = m_cnt < m_dact[i];
         edge_seen = e && !m_last;
         m_last = e;
         if (p) m_psh = v;
         for (int i = 0; i < CH; i++) if (d[i]) m_dsh[i] = v;
         m_roll = edge_seen && m_cnt == 0;
         if (m_roll) begin
            m_pact = m_psh;
            for (int i = 0; i < CH; i++) m_dact[i] = m_dsh[i];
            m_cnt = m_pact;
         end else if (edge_seen) m_cnt = m_cnt - 1;
      end
      x.cnt = W'(m_cnt);
      x.per = W'(m_psh);
      for (int i = 0; i < CH; i++) x.duty[i*W +: W] = W'(m_dact[i]);
      x.roll = m_roll;
      x.pwm = m_pwm;
      q.push_back(x);
   endtask
   task automatic pulse(input int n);
      for (int k = 0; k < n; k++) begin
         step(0, 1, 0, '0, 0);
         step(0, 0, 0, '0, 0);
      end
   endtask
   task automatic pulse_to(input int target);
      for (int k = 0; k < 600 && m_cnt != target; k++) pulse(1);
      tests++;
      if (m_cnt != target) begin
         fails++;
         $display("FAIL reach_count: got %0d expected %0d", m_cnt, target);
      end
   endtask
   initial begin
      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 0);
      pulse(10);
      pulse_to(5);
      step(0, 0, 0, 4'b0001, 5);
      step(0, 0, 0, 4'b0010, 10);
      pulse(25);
      pulse_to(7);
      step(0, 0, 1, '0, 3);
      pulse(20);
      pulse_to(1);
      step(0, 1, 0, '0, 0);
      step(0, 0, 0, '0, 0);
      step(0, 1, 1, '0, 4);
      step(0, 0, 0, '0, 0);
      pulse(4);
      step(0, 1, 0, 4'b0100, 2);
      step(0, 0, 0, '0, 0);
      pulse(12);
      for (int k = 0; k < 20; k++) step(0, 1, 0, '0, 0);
      step(0, 0, 0, '0, 0);
      step(0, 0, 0, 4'b0001, 5);
      pulse_to(0);
      pulse(2);
      step(1, 1, 1, 4'b1111, 7);
      step(0, 0, 0, '0, 0);
      for (int k = 0; k < 1500; k++) begin
         step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 15) == 0,
              ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0,
              $urandom_range(0, 12));
      end
      for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
      #5;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
